// File: rtl/aludec_seq_pkg.sv
// Shared constants, state encoding and decode helpers for the ID/EX ALU-control decoder.
package aludec_seq_pkg;

  typedef enum logic [1:0] {EMPTY, FULL, MDU} state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
  localparam logic [7:0] EXE_SW_OP    = 8'b1110_1011;
  localparam logic [7:0] EXE_BEQ_OP   = 8'b0101_0001;

  typedef struct packed {
    logic [7:0] code;
    logic       ri;
  } dec_t;

  function automatic logic is_mdu(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_SPECIAL) &&
           (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
  endfunction

  // Multiply/divide ops decode as reserved when the sequencer is not built.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct,
                                  input logic mdu_en);
    dec_t d;
    d.code = '0;
    d.ri   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_AND:   d.code = EXE_AND_OP;
          F_OR:    d.code = EXE_OR_OP;
          F_XOR:   d.code = EXE_XOR_OP;
          F_NOR:   d.code = EXE_NOR_OP;
          F_SLL:   d.code = EXE_SLL_OP;
          F_SRL:   d.code = EXE_SRL_OP;
          F_SRA:   d.code = EXE_SRA_OP;
          F_SLLV:  d.code = EXE_SLLV_OP;
          F_SRLV:  d.code = EXE_SRLV_OP;
          F_SRAV:  d.code = EXE_SRAV_OP;
          F_ADD:   d.code = EXE_ADD_OP;
          F_ADDU:  d.code = EXE_ADDU_OP;
          F_SUB:   d.code = EXE_SUB_OP;
          F_SUBU:  d.code = EXE_SUBU_OP;
          F_SLT:   d.code = EXE_SLT_OP;
          F_SLTU:  d.code = EXE_SLTU_OP;
          F_MULT:  if (mdu_en) d.code = EXE_MULT_OP;  else d.ri = 1'b1;
          F_MULTU: if (mdu_en) d.code = EXE_MULTU_OP; else d.ri = 1'b1;
          F_DIV:   if (mdu_en) d.code = EXE_DIV_OP;   else d.ri = 1'b1;
          F_DIVU:  if (mdu_en) d.code = EXE_DIVU_OP;  else d.ri = 1'b1;
          default: d.ri = 1'b1;
        endcase
      end
      OP_ANDI:  d.code = EXE_ANDI_OP;
      OP_XORI:  d.code = EXE_XORI_OP;
      OP_LUI:   d.code = EXE_LUI_OP;
      OP_ORI:   d.code = EXE_ORI_OP;
      OP_ADDI:  d.code = EXE_ADDI_OP;
      OP_ADDIU: d.code = EXE_ADDIU_OP;
      OP_SLTI:  d.code = EXE_SLTI_OP;
      OP_SLTIU: d.code = EXE_SLTIU_OP;
      OP_LW:    d.code = EXE_LW_OP;
      OP_SW:    d.code = EXE_SW_OP;
      OP_BEQ:   d.code = EXE_BEQ_OP;
      default:  d.ri = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/aludec_mdu_cnt.sv
// Busy-cycle counter for multiply/divide sequencing: load, decrement to zero, zero flag.
module aludec_mdu_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (clear)              count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aludec_seq.sv
// Registered ALU-control decoder with one-entry valid/ready hold and multiply/divide busy sequencing.
// Define ALUDEC_MDU_EN to build the MULT/DIV sequencer; otherwise those ops decode as reserved.
module aludec_seq #(
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              ri,
  output logic              busy,
  output logic              mdu_start,
  output logic              mdu_sign,
  output logic              mdu_abort
);
  import aludec_seq_pkg::*;

`ifdef ALUDEC_MDU_EN
  localparam logic MDU_EN = 1'b1;
`else
  localparam logic MDU_EN = 1'b0;
`endif

  if (MULT_CYCLES == 0 || DIV_CYCLES == 0) begin : g_cfg_check
    $error("aludec_seq: MULT_CYCLES and DIV_CYCLES must be at least 1");
  end

  state_t state, state_nxt;
  dec_t   dcd;
  logic   accept;
  logic   held_mdu;
  logic   cnt_zero;

  assign dcd    = decode(op, funct, MDU_EN);
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = FULL;
        FULL: begin
          if (out_ready) begin
            if (held_mdu)     state_nxt = MDU;
            else if (!accept) state_nxt = EMPTY;
          end
        end
        MDU:     if (cnt_zero) state_nxt = EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    mdu_start = 1'b0;
    mdu_abort = 1'b0;
    case (state)
      EMPTY: in_ready = 1'b1;
      FULL: begin
        in_ready  = out_ready & ~held_mdu;
        mdu_start = out_ready & held_mdu & ~flush;
      end
      MDU:     mdu_abort = flush & MDU_EN;
      default: ;
    endcase
  end

  assign out_valid = (state == FULL);
  assign busy      = MDU_EN & (state == MDU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alucontrol <= '0;
      ri         <= 1'b0;
    end else if (accept) begin
      alucontrol <= CTRL_W'(dcd.code);
      ri         <= dcd.ri;
    end
  end

`ifdef ALUDEC_MDU_EN
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  logic             held_div;
  logic             sign_q;
  logic [CNT_W-1:0] cnt_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_mdu <= 1'b0;
      held_div <= 1'b0;
      sign_q   <= 1'b0;
    end else if (accept) begin
      held_mdu <= is_mdu(op, funct);
      held_div <= is_mdu(op, funct) && (funct == F_DIV || funct == F_DIVU);
      sign_q   <= is_mdu(op, funct) && (funct == F_MULT || funct == F_DIV);
    end
  end

  // Loading N-1 and leaving MDU on the zero count gives exactly N busy cycles.
  assign cnt_load = held_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
  assign mdu_sign = sign_q;

  aludec_mdu_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (mdu_start),
    .load_val (cnt_load),
    .dec      (state == MDU),
    .zero     (cnt_zero)
  );
`else
  assign held_mdu = 1'b0;
  assign cnt_zero = 1'b1;
  assign mdu_sign = 1'b0;
`endif

endmodule

// File: tb/tb_aludec_seq.sv
// Directed self-checking bench for aludec_seq; expectations follow ALUDEC_MDU_EN when defined.
module tb_aludec_seq;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [5:0] op, funct;
  logic       in_ready, out_valid, ri, busy, mdu_start, mdu_sign, mdu_abort;
  logic [7:0] alucontrol;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  aludec_seq #(.CTRL_W(8), .MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .op         (op),
    .funct      (funct),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alucontrol (alucontrol),
    .ri         (ri),
    .busy       (busy),
    .mdu_start  (mdu_start),
    .mdu_sign   (mdu_sign),
    .mdu_abort  (mdu_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f);
    in_valid = 1'b1;
    op       = o;
    funct    = f;
  endtask

  // Counts busy cycles from the current sample point, bounded.
  task automatic count_busy(output int unsigned n, output int unsigned low_ready,
                            output int unsigned starts);
    n = 0; low_ready = 0; starts = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      if (!in_ready) low_ready++;
      if (mdu_start) starts++;
      step();
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [7:0] code;
    logic       ri;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int unsigned n, lo, st;

    vecs[0]  = '{6'h00, 6'h00, 8'h7C, 1'b0};
    vecs[1]  = '{6'h00, 6'h07, 8'h07, 1'b0};
    vecs[2]  = '{6'h00, 6'h27, 8'h27, 1'b0};
    vecs[3]  = '{6'h00, 6'h2B, 8'h2B, 1'b0};
    vecs[4]  = '{6'h0F, 6'h2B, 8'h5C, 1'b0};
    vecs[5]  = '{6'h2B, 6'h00, 8'hEB, 1'b0};
    vecs[6]  = '{6'h04, 6'h11, 8'h51, 1'b0};
    vecs[7]  = '{6'h0E, 6'h00, 8'h5B, 1'b0};
    vecs[8]  = '{6'h09, 6'h00, 8'h56, 1'b0};
    vecs[9]  = '{6'h0B, 6'h00, 8'h58, 1'b0};
    vecs[10] = '{6'h02, 6'h00, 8'h00, 1'b1};
    vecs[11] = '{6'h00, 6'h01, 8'h00, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; funct = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alucontrol", 32'(alucontrol), 0);
    chk("rst_ri", 32'(ri), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mdu_start", 32'(mdu_start), 0);
    chk("rst_mdu_abort", 32'(mdu_abort), 0);
    chk("rst_mdu_sign", 32'(mdu_sign), 0);
    rst_n = 1'b1;
    step();

    // Back-to-back ADD, ORI, LW
    out_ready = 1'b1;
    issue(6'h00, 6'h20); settle();
    chk("b2b_ready0", 32'(in_ready), 1);
    step();
    chk("b2b_add_valid", 32'(out_valid), 1);
    chk("b2b_add", 32'(alucontrol), 32'h20);
    issue(6'h0D, 6'h00); settle();
    chk("b2b_ready1", 32'(in_ready), 1);
    step();
    chk("b2b_ori", 32'(alucontrol), 32'h5A);
    chk("b2b_ori_valid", 32'(out_valid), 1);
    issue(6'h23, 6'h00); settle();
    chk("b2b_ready2", 32'(in_ready), 1);
    step();
    chk("b2b_lw", 32'(alucontrol), 32'hE3);
    in_valid = 1'b0;
    step();
    chk("b2b_drained", 32'(out_valid), 0);

    // Reserved encodings
    issue(6'h3F, 6'h00); step();
    chk("ri_op_ri", 32'(ri), 1);
    chk("ri_op_code", 32'(alucontrol), 0);
    chk("ri_op_valid", 32'(out_valid), 1);
    issue(6'h00, 6'h3F); step();
    chk("ri_funct_ri", 32'(ri), 1);
    chk("ri_funct_code", 32'(alucontrol), 0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].funct); step();
      chk($sformatf("vec%0d_code", i), 32'(alucontrol), 32'(vecs[i].code));
      chk($sformatf("vec%0d_ri", i), 32'(ri), 32'(vecs[i].ri));
    end
    in_valid = 1'b0;
    step();

    // Back-pressure hold, then consume with same-cycle accept
    out_ready = 1'b0;
    issue(6'h00, 6'h20); step();
    issue(6'h0D, 6'h00);
    for (int unsigned i = 0; i < 5; i++) begin
      settle();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_hold", 32'(alucontrol), 32'h20);
      step();
    end
    out_ready = 1'b1; settle();
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_code", 32'(alucontrol), 32'h5A);
    in_valid = 1'b0;
    step();

    // Flush while FULL with a new instruction offered
    out_ready = 1'b0;
    issue(6'h00, 6'h20); step();
    issue(6'h0D, 6'h00); out_ready = 1'b1; flush = 1'b1; settle();
    chk("flush_full_abort", 32'(mdu_abort), 0);
    step();
    flush = 1'b0; in_valid = 1'b0; settle();
    chk("flush_full_valid", 32'(out_valid), 0);
    chk("flush_full_noaccept", 32'(alucontrol), 32'h20);
    chk("flush_full_ready", 32'(in_ready), 1);

`ifdef ALUDEC_MDU_EN
    // DIV: 32 busy cycles
    issue(6'h00, 6'h1A); step();
    in_valid = 1'b0; settle();
    chk("div_code", 32'(alucontrol), 32'h1A);
    chk("div_sign", 32'(mdu_sign), 1);
    chk("div_ready_full", 32'(in_ready), 0);
    chk("div_start", 32'(mdu_start), 1);
    step();
    chk("div_start_pulse", 32'(mdu_start), 0);
    chk("div_valid_mdu", 32'(out_valid), 0);
    count_busy(n, lo, st);
    chk("div_busy_cycles", n, 32);
    chk("div_ready_low", lo, 32);
    chk("div_extra_starts", st, 0);
    chk("div_ready_after", 32'(in_ready), 1);

    // MULTU: 4 busy cycles, unsigned
    issue(6'h00, 6'h19); step();
    in_valid = 1'b0; settle();
    chk("multu_sign", 32'(mdu_sign), 0);
    chk("multu_code", 32'(alucontrol), 32'h19);
    chk("multu_start", 32'(mdu_start), 1);
    step();
    count_busy(n, lo, st);
    chk("multu_busy_cycles", n, 4);

    // Flush on the 10th DIV busy cycle
    issue(6'h00, 6'h1A); step();
    in_valid = 1'b0; step();
    for (int unsigned i = 0; i < 9; i++) step();
    chk("abort_busy_before", 32'(busy), 1);
    flush = 1'b1; settle();
    chk("abort_pulse", 32'(mdu_abort), 1);
    step();
    flush = 1'b0; settle();
    chk("abort_pulse_end", 32'(mdu_abort), 0);
    chk("abort_busy_after", 32'(busy), 0);
    chk("abort_ready_after", 32'(in_ready), 1);

    // Flush on the final MULT cycle (count = 0)
    issue(6'h00, 6'h18); step();
    in_valid = 1'b0; settle();
    chk("mult_sign", 32'(mdu_sign), 1);
    step(); step(); step(); step();
    chk("last_busy", 32'(busy), 1);
    flush = 1'b1; settle();
    chk("last_abort", 32'(mdu_abort), 1);
    step();
    flush = 1'b0; settle();
    chk("last_busy_after", 32'(busy), 0);

    // Asynchronous reset mid-operation
    issue(6'h00, 6'h1A); step();
    in_valid = 1'b0; step(); step(); step();
    chk("rstmid_busy_before", 32'(busy), 1);
    rst_n = 1'b0; settle();
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_abort", 32'(mdu_abort), 0);
    chk("rstmid_sign", 32'(mdu_sign), 0);
    chk("rstmid_code", 32'(alucontrol), 0);
    chk("rstmid_ready", 32'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
`else
    // Without the sequencer DIV is reserved and never goes busy
    issue(6'h00, 6'h1A); step();
    in_valid = 1'b0; settle();
    chk("nomdu_div_ri", 32'(ri), 1);
    chk("nomdu_div_code", 32'(alucontrol), 0);
    chk("nomdu_div_valid", 32'(out_valid), 1);
    chk("nomdu_start", 32'(mdu_start), 0);
    chk("nomdu_ready", 32'(in_ready), 1);
    st = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (busy || mdu_start || mdu_sign) st++;
      step();
    end
    chk("nomdu_never_busy", st, 0);
    chk("nomdu_drained", 32'(out_valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
